// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Drives one pipelined MAC (MAC_LAT-cycle issue-to-o_valid, sum_out = sum_in + a*b)
//   through a dot product of len operand pairs. Consecutive elements are spread
//   round-robin over MAC_LAT partial-sum lanes so back-to-back issues never wait on
//   a previous result. The lanes are summed into one 48-bit result at the end.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   start, len                     begin a dot product of len elements (IDLE only)
//   busy                           high in any state except IDLE
//   in_valid, in_ready, in_a, in_b operand pair stream (22-bit signed)
//   mac_i_valid, mac_a, mac_b,
//   mac_sum_in                     MAC issue side (owned exclusively by this block)
//   mac_o_valid, mac_sum_out       MAC return side
//   res_valid, res_ready, res_data 48-bit signed result handshake
//   err                            sticky: MAC o_valid disagreed with the tag pipe
//
// Build option
//   SEQ_SAT_EN  defined: lane reduction is done wide and clamped to the signed
//               48-bit range. Undefined: reduction wraps at 48 bits.
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_RUN    | accepting operand pairs and issuing them to the MAC
//   S_DRAIN  | all elements issued, waiting for in-flight MAC results
//   S_REDUCE | summing the partial-sum lanes into res_data
//   S_OUT    | res_valid high until res_ready
module mac_dot_sequencer #(
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [21:0]      in_a,
    input  logic [21:0]      in_b,
    output logic             mac_i_valid,
    output logic [21:0]      mac_a,
    output logic [21:0]      mac_b,
    output logic [47:0]      mac_sum_in,
    input  logic             mac_o_valid,
    input  logic [47:0]      mac_sum_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             err
);

    localparam int LANE_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_REDUCE,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic signed [47:0] lane_p   [MAC_LAT];
    logic [LANE_W-1:0]  tag_lane [MAC_LAT];
    logic [MAC_LAT-1:0] tag_v;
    logic [LEN_W-1:0]   issued;
    logic [LEN_W-1:0]   len_r;
    logic [LANE_W-1:0]  lane_ptr;

    logic               issue;
    logic               start_acc;
    logic               last_issue;
    logic               head_v;
    logic [LANE_W-1:0]  head_lane;
    logic               body_busy;
    logic [47:0]        red_sum;

    assign start_acc  = start && (state == S_IDLE);
    assign in_ready   = (state == S_RUN);
    assign issue      = in_valid && in_ready;
    assign last_issue = issue && (issued == len_r - LEN_W'(1));
    assign head_v     = tag_v[MAC_LAT-1];
    assign head_lane  = tag_lane[MAC_LAT-1];
    assign busy       = (state != S_IDLE);
    assign res_valid  = (state == S_OUT);

    // Every stage except the head: once these are empty, the only remaining
    // result (if any) is written to its lane on this edge, so REDUCE next
    // cycle sees final lane values.
    always_comb begin
        body_busy = 1'b0;
        for (int i = 0; i < MAC_LAT - 1; i++) begin
            body_busy = body_busy | tag_v[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_OUT : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!body_busy) begin
                    state_nxt = S_REDUCE;
                end
            end
            S_REDUCE: state_nxt = S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // MAC issue side. When the lane's previous result returns in the same
    // cycle it has not reached lane_p yet, so it is forwarded from the MAC.
    always_comb begin
        mac_i_valid = issue;
        mac_a       = '0;
        mac_b       = '0;
        mac_sum_in  = '0;
        if (issue) begin
            mac_a = in_a;
            mac_b = in_b;
            if (head_v && (head_lane == lane_ptr)) begin
                mac_sum_in = mac_sum_out;
            end else begin
                mac_sum_in = lane_p[lane_ptr];
            end
        end
    end

`ifdef SEQ_SAT_EN
    localparam int RED_W = 48 + $clog2(MAC_LAT);
    localparam logic signed [RED_W-1:0] SAT_MAX = {{(RED_W-47){1'b0}}, {47{1'b1}}};
    localparam logic signed [RED_W-1:0] SAT_MIN = {{(RED_W-47){1'b1}}, {47{1'b0}}};

    logic signed [RED_W-1:0] red_acc;

    always_comb begin
        red_acc = '0;
        for (int i = 0; i < MAC_LAT; i++) begin
            red_acc = red_acc + RED_W'(lane_p[i]);
        end
        if (red_acc > SAT_MAX) begin
            red_sum = 48'h7FFF_FFFF_FFFF;
        end else if (red_acc < SAT_MIN) begin
            red_sum = 48'h8000_0000_0000;
        end else begin
            red_sum = red_acc[47:0];
        end
    end
`else
    always_comb begin
        red_sum = '0;
        for (int i = 0; i < MAC_LAT; i++) begin
            red_sum = red_sum + lane_p[i];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tag_v    <= '0;
            issued   <= '0;
            len_r    <= '0;
            lane_ptr <= '0;
            err      <= 1'b0;
            res_data <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                lane_p[i]   <= '0;
                tag_lane[i] <= '0;
            end
        end else begin
            state <= state_nxt;

            tag_v[0]    <= issue;
            tag_lane[0] <= lane_ptr;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_lane[i] <= tag_lane[i-1];
            end

            if (start_acc) begin
                len_r    <= len;
                issued   <= '0;
                lane_ptr <= '0;
                err      <= 1'b0;
                res_data <= '0;
                for (int i = 0; i < MAC_LAT; i++) begin
                    lane_p[i] <= '0;
                end
            end else begin
                // Lane write follows our own tag, not the MAC's o_valid;
                // a disagreement only raises err.
                if (head_v) begin
                    lane_p[head_lane] <= mac_sum_out;
                end
                if (head_v != mac_o_valid) begin
                    err <= 1'b1;
                end
                if (issue) begin
                    issued   <= issued + LEN_W'(1);
                    lane_ptr <= (lane_ptr == LANE_W'(MAC_LAT - 1)) ? '0 : lane_ptr + LANE_W'(1);
                end
                if (state == S_REDUCE) begin
                    res_data <= red_sum;
                end
            end
        end
    end

endmodule
